next_hop_scheduler: RTL and testbench
=====================================

Name: next_hop_scheduler

Overview:
Sequencer that scans the node's neighbor table, one entry per read, and selects the next-hop neighbor with the highest learned Q-value. It runs after the reward/Q-update stage so that data packets are forwarded to the best current neighbor. The block owns the neighbor-table read port for the duration of a scan. It reports the winner, or a no-route condition, to the packet-forwarding logic with a one-cycle done pulse.

Parameters:
WORD_WIDTH, 16, width of node ID, Q-value and hop-count fields
MAX_NEIGHBORS, 16, neighbor-table depth (power of two)
NB_ADDR_WIDTH, $clog2(MAX_NEIGHBORS), neighbor-table address width

Ports:
clk  input  1  system clock
nrst  input  1  synchronous active-low reset
en  input  1  global enable; low freezes FSM and all registers
start  input  1  request a scan; honoured only in IDLE with en=1
neighborCount  input  NB_ADDR_WIDTH+1  number of valid table entries (0..MAX_NEIGHBORS), sampled at start
hopsFromSink  input  WORD_WIDTH  this node's hop count, sampled at start
nt_rd_en  output  1  neighbor-table read strobe
nt_addr  output  NB_ADDR_WIDTH  neighbor-table read address
nt_nodeID  input  WORD_WIDTH  entry node ID, valid 1 cycle after strobe, held while strobe low
nt_qValue  input  WORD_WIDTH  entry Q-value, unsigned, same timing
nt_hops  input  WORD_WIDTH  entry hops-from-sink, same timing
nt_lowE  input  1  entry low-energy flag, same timing
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, results valid
noRoute  output  1  last scan found no eligible neighbor
nextHopID  output  WORD_WIDTH  selected neighbor ID
nextHopQ  output  WORD_WIDTH  selected neighbor Q-value
nextHopIdx  output  NB_ADDR_WIDTH  selected table index

Behaviour:
- Reset (nrst=0 at a clk edge): state IDLE. All outputs 0: busy, done, noRoute, nt_rd_en, nt_addr, nextHop*. Internal index and best registers are cleared. A reset in mid-scan aborts the scan with no done pulse.
- en=0: no state or register changes; nt_rd_en forced 0; done forced 0 and its pulse is deferred; the table holds its read data.
- Cycle 0 is the cycle in which start=1 is seen in IDLE.
- FSM states: IDLE, READ, COMPARE, DONE.
- IDLE: on start, latch neighborCount and hopsFromSink, clear idx, clear the best-valid flag and best registers. Go to DONE if count=0, else READ.
- READ: nt_rd_en=1, nt_addr=idx. Always go to COMPARE.
- COMPARE: the table data is valid. Entry is eligible iff nt_hops <= latched hopsFromSink.
- Update rule: an eligible entry replaces the best if no best exists yet, or if nt_qValue > bestQ, or if nt_qValue == bestQ and nt_hops < bestHops. On a full tie the lower index is kept.
- COMPARE exit: if idx == count-1, go to DONE; else idx+1 and go to READ.
- DONE: done=1 for exactly one cycle, then IDLE.
  - If a best exists: nextHopID/Q/Idx are loaded from the best registers and noRoute=0.
  - Otherwise: noRoute=1 and nextHop* keep their previous values.
- Result outputs change only in DONE.
- Latency: done asserts in cycle 2N+2 for N>=1, and in cycle 2 for N=0. busy is high from cycle 1 through the done cycle.
- start is ignored while busy; there is no queuing.
- neighborCount > MAX_NEIGHBORS is clamped to MAX_NEIGHBORS.
- Q comparison is unsigned and full-width; no arithmetic is performed on Q.

Optional Feature:
Macro NHS_LOW_ENERGY_SKIP_EN.
- Defined: entries with nt_lowE=1 are ineligible. If every otherwise-eligible entry is low-energy, noRoute=1.
- Undefined: nt_lowE is ignored; the port remains present and unused.

Test Plan:
- Reset: hold nrst=0 for 3 cycles with start=1 -> all outputs 0; no read strobe.
- Scan: N=3, Q={0x0100,0x0300,0x0200}, hops={2,2,2}, hopsFromSink=3 -> done in cycle 8, nextHopIdx=1, nextHopQ=0x0300, noRoute=0, exactly 3 strobes at addr 0,1,2.
- Ties: N=2, Q={0x0200,0x0200}, hops={3,1}, hopsFromSink=3 -> Idx=1. Repeat with hops={1,1} -> Idx=0.
- No route: N=2, hops={5,6}, hopsFromSink=4 after a prior win at Idx=1 -> noRoute=1, nextHop* unchanged. N=0 -> done in cycle 2, noRoute=1, no strobes.
- Disturbances: start pulsed mid-scan -> ignored, single done. en=0 for 4 cycles mid-scan -> done delayed exactly 4 cycles, same result. nrst=0 mid-scan -> IDLE, no done.
- Macro: NHS_LOW_ENERGY_SKIP_EN, N=2, Q={0x0400,0x0100}, lowE={1,0}, hops eligible -> Idx=1. Without the macro -> Idx=0.

Source files
------------

// File: rtl/next_hop_scheduler.sv
// Next-hop selector: scans the neighbor table one entry per read and reports the
// eligible neighbor with the highest Q-value. Optional macro: NHS_LOW_ENERGY_SKIP_EN.
module next_hop_scheduler #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned MAX_NEIGHBORS = 16,
  parameter int unsigned NB_ADDR_WIDTH = $clog2(MAX_NEIGHBORS)
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     en,
  input  logic                     start,
  input  logic [NB_ADDR_WIDTH:0]   neighborCount,
  input  logic [WORD_WIDTH-1:0]    hopsFromSink,
  output logic                     nt_rd_en,
  output logic [NB_ADDR_WIDTH-1:0] nt_addr,
  input  logic [WORD_WIDTH-1:0]    nt_nodeID,
  input  logic [WORD_WIDTH-1:0]    nt_qValue,
  input  logic [WORD_WIDTH-1:0]    nt_hops,
  input  logic                     nt_lowE,
  output logic                     busy,
  output logic                     done,
  output logic                     noRoute,
  output logic [WORD_WIDTH-1:0]    nextHopID,
  output logic [WORD_WIDTH-1:0]    nextHopQ,
  output logic [NB_ADDR_WIDTH-1:0] nextHopIdx
);

  localparam int unsigned CntW = NB_ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_NEIGHBORS);

  typedef enum logic [1:0] {StIdle, StRead, StCompare, StDone} state_e;

  state_e                   state_q, state_d;
  logic [NB_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CntW-1:0]          count_q, count_d;
  logic [WORD_WIDTH-1:0]    hfs_q, hfs_d;
  logic                     best_valid_q, best_valid_d;
  logic [WORD_WIDTH-1:0]    best_id_q, best_id_d;
  logic [WORD_WIDTH-1:0]    best_qv_q, best_qv_d;
  logic [WORD_WIDTH-1:0]    best_hops_q, best_hops_d;
  logic [NB_ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
  logic                     done_q, done_d;
  logic                     no_route_q, no_route_d;
  logic [WORD_WIDTH-1:0]    next_id_q, next_id_d;
  logic [WORD_WIDTH-1:0]    next_qv_q, next_qv_d;
  logic [NB_ADDR_WIDTH-1:0] next_idx_q, next_idx_d;

  logic [CntW-1:0] cnt_clamp;
  logic            eligible;
  logic            better;
  logic            last_entry;

  assign cnt_clamp = (neighborCount > MaxCnt) ? MaxCnt : neighborCount;

`ifdef NHS_LOW_ENERGY_SKIP_EN
  assign eligible = (nt_hops <= hfs_q) && !nt_lowE;
`else
  logic unused_lowe;
  assign unused_lowe = nt_lowE;
  assign eligible    = (nt_hops <= hfs_q);
`endif

  // Strict compares keep the lower index on a full tie.
  assign better = !best_valid_q || (nt_qValue > best_qv_q) ||
                  ((nt_qValue == best_qv_q) && (nt_hops < best_hops_q));

  assign last_entry = ({1'b0, idx_q} == (count_q - CntW'(1)));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    hfs_d        = hfs_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_qv_d    = best_qv_q;
    best_hops_d  = best_hops_q;
    best_idx_d   = best_idx_q;
    done_d       = done_q;
    no_route_d   = no_route_q;
    next_id_d    = next_id_q;
    next_qv_d    = next_qv_q;
    next_idx_d   = next_idx_q;

    // With en low everything holds, including a pending done pulse.
    if (en) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          // done_q high means the previous scan's done cycle is still in progress.
          if (start && !done_q) begin
            count_d      = cnt_clamp;
            hfs_d        = hopsFromSink;
            idx_d        = '0;
            best_valid_d = 1'b0;
            best_id_d    = '0;
            best_qv_d    = '0;
            best_hops_d  = '0;
            best_idx_d   = '0;
            state_d      = (cnt_clamp == '0) ? StDone : StRead;
          end
        end
        StRead: begin
          state_d = StCompare;
        end
        StCompare: begin
          if (eligible && better) begin
            best_valid_d = 1'b1;
            best_id_d    = nt_nodeID;
            best_qv_d    = nt_qValue;
            best_hops_d  = nt_hops;
            best_idx_d   = idx_q;
          end
          if (last_entry) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + NB_ADDR_WIDTH'(1);
            state_d = StRead;
          end
        end
        StDone: begin
          done_d = 1'b1;
          if (best_valid_q) begin
            no_route_d = 1'b0;
            next_id_d  = best_id_q;
            next_qv_d  = best_qv_q;
            next_idx_d = best_idx_q;
          end else begin
            no_route_d = 1'b1;
          end
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      count_q      <= '0;
      hfs_q        <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_qv_q    <= '0;
      best_hops_q  <= '0;
      best_idx_q   <= '0;
      done_q       <= 1'b0;
      no_route_q   <= 1'b0;
      next_id_q    <= '0;
      next_qv_q    <= '0;
      next_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      hfs_q        <= hfs_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_qv_q    <= best_qv_d;
      best_hops_q  <= best_hops_d;
      best_idx_q   <= best_idx_d;
      done_q       <= done_d;
      no_route_q   <= no_route_d;
      next_id_q    <= next_id_d;
      next_qv_q    <= next_qv_d;
      next_idx_q   <= next_idx_d;
    end
  end

  // The done pulse is registered, so busy also covers that trailing cycle.
  assign busy       = (state_q != StIdle) || done_q;
  assign done       = done_q && en;
  assign nt_rd_en   = en && (state_q == StRead);
  assign nt_addr    = idx_q;
  assign noRoute    = no_route_q;
  assign nextHopID  = next_id_q;
  assign nextHopQ   = next_qv_q;
  assign nextHopIdx = next_idx_q;

endmodule

// File: tb/tb_next_hop_scheduler.sv
// Directed, table-driven bench for next_hop_scheduler with a behavioural neighbor table.
module tb_next_hop_scheduler;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        start;
  logic [4:0]  neighborCount;
  logic [15:0] hopsFromSink;
  logic        nt_rd_en;
  logic [3:0]  nt_addr;
  logic [15:0] nt_nodeID;
  logic [15:0] nt_qValue;
  logic [15:0] nt_hops;
  logic        nt_lowE;
  logic        busy;
  logic        done;
  logic        noRoute;
  logic [15:0] nextHopID;
  logic [15:0] nextHopQ;
  logic [3:0]  nextHopIdx;

  next_hop_scheduler dut (
    .clk           (clk),
    .nrst          (nrst),
    .en            (en),
    .start         (start),
    .neighborCount (neighborCount),
    .hopsFromSink  (hopsFromSink),
    .nt_rd_en      (nt_rd_en),
    .nt_addr       (nt_addr),
    .nt_nodeID     (nt_nodeID),
    .nt_qValue     (nt_qValue),
    .nt_hops       (nt_hops),
    .nt_lowE       (nt_lowE),
    .busy          (busy),
    .done          (done),
    .noRoute       (noRoute),
    .nextHopID     (nextHopID),
    .nextHopQ      (nextHopQ),
    .nextHopIdx    (nextHopIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural neighbor table: registered read, data held while strobe low.
  logic [15:0] tbl_id   [16];
  logic [15:0] tbl_q    [16];
  logic [15:0] tbl_hops [16];
  logic        tbl_lowe [16];
  int          strobes = 0;
  logic [3:0]  addr_log [256];

  always @(posedge clk) begin
    if (nt_rd_en) begin
      addr_log[strobes % 256] <= nt_addr;
      strobes   <= strobes + 1;
      nt_nodeID <= tbl_id[nt_addr];
      nt_qValue <= tbl_q[nt_addr];
      nt_hops   <= tbl_hops[nt_addr];
      nt_lowE   <= tbl_lowe[nt_addr];
    end
  end

  typedef struct {
    int              n;
    int              hfs;
    logic [3:0][15:0] q;
    logic [3:0][15:0] h;
    logic [3:0]      le;
    int              sa;   // cycle of a stray start pulse (0 = none)
    int              eo;   // first cycle with en low
    int              el;   // number of cycles with en low
    bit              nr;
    int              idx;
    logic [15:0]     eq;
    int              lat;
    int              st;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int hfs, input logic [63:0] q,
                              input logic [63:0] h, input logic [3:0] le, input int sa,
                              input int eo, input int el, input bit nr, input int idx,
                              input logic [15:0] eq, input int lat, input int st);
    vec_t v;
    v.n = n; v.hfs = hfs; v.q = q; v.h = h; v.le = le; v.sa = sa; v.eo = eo; v.el = el;
    v.nr = nr; v.idx = idx; v.eq = eq; v.lat = lat; v.st = st;
    return v;
  endfunction

  task automatic load_table(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      tbl_id[i]   = 16'h0100 + 16'(i);
      tbl_q[i]    = (i < 4) ? v.q[i] : 16'h1000 + 16'(i);
      tbl_hops[i] = (i < 4) ? v.h[i] : 16'h0000;
      tbl_lowe[i] = (i < 4) ? v.le[i] : 1'b0;
    end
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int lat;
    int st0;
    int extra;
    bit busy_at_done;
    lat = -1;
    extra = 0;
    busy_at_done = 1'b0;
    @(negedge clk);
    load_table(v);
    st0 = strobes;
    neighborCount = 5'(v.n);
    hopsFromSink  = 16'(v.hfs);
    en = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = (c == v.sa);
      en = !(v.el > 0 && c >= v.eo && c < v.eo + v.el);
      #1;
      if (done) begin
        lat = c;
        busy_at_done = busy;
        break;
      end
    end
    chk($sformatf("v%0d done_cycle", k), lat, v.lat);
    chk($sformatf("v%0d noRoute", k), noRoute, v.nr);
    chk($sformatf("v%0d nextHopIdx", k), nextHopIdx, v.idx);
    chk($sformatf("v%0d nextHopQ", k), nextHopQ, v.eq);
    chk($sformatf("v%0d nextHopID", k), nextHopID, 16'h0100 + 16'(v.idx));
    chk($sformatf("v%0d busy_at_done", k), busy_at_done, 1);
    start = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) extra++;
    end
    chk($sformatf("v%0d extra_done", k), extra, 0);
    chk($sformatf("v%0d busy_after", k), busy, 0);
    chk($sformatf("v%0d strobes", k), strobes - st0, v.st);
    for (int i = 0; i < v.st && i < 16; i++)
      chk($sformatf("v%0d addr%0d", k, i), addr_log[(st0 + i) % 256], i);
  endtask

  vec_t vecs[12];

  initial begin
    int st_r;
    int dn;
    vecs[0]  = mk(3, 3, 64'h0000_0200_0300_0100, 64'h0000_0002_0002_0002, 4'b0000,
                  0, 0, 0, 1'b0, 1, 16'h0300, 8, 3);
    vecs[1]  = mk(2, 3, 64'h0000_0000_0200_0200, 64'h0000_0000_0001_0003, 4'b0000,
                  0, 0, 0, 1'b0, 1, 16'h0200, 6, 2);
    vecs[2]  = mk(2, 3, 64'h0000_0000_0200_0200, 64'h0000_0000_0001_0001, 4'b0000,
                  0, 0, 0, 1'b0, 0, 16'h0200, 6, 2);
    vecs[3]  = mk(2, 4, 64'h0000_0000_0007_0005, 64'h0000_0000_0001_0001, 4'b0000,
                  0, 0, 0, 1'b0, 1, 16'h0007, 6, 2);
    vecs[4]  = mk(2, 4, 64'h0000_0000_0009_0009, 64'h0000_0000_0006_0005, 4'b0000,
                  0, 0, 0, 1'b1, 1, 16'h0007, 6, 2);
    vecs[5]  = mk(0, 4, 64'h0, 64'h0, 4'b0000,
                  0, 0, 0, 1'b1, 1, 16'h0007, 2, 0);
    vecs[6]  = mk(3, 3, 64'h0000_0200_0900_0100, 64'h0000_0002_0005_0002, 4'b0000,
                  0, 0, 0, 1'b0, 2, 16'h0200, 8, 3);
    vecs[7]  = mk(2, 0, 64'h0000_0000_ffff_8000, 64'h0, 4'b0000,
                  0, 0, 0, 1'b0, 1, 16'hffff, 6, 2);
`ifdef NHS_LOW_ENERGY_SKIP_EN
    vecs[8]  = mk(2, 0, 64'h0000_0000_0100_0400, 64'h0, 4'b0001,
                  0, 0, 0, 1'b0, 1, 16'h0100, 6, 2);
`else
    vecs[8]  = mk(2, 0, 64'h0000_0000_0100_0400, 64'h0, 4'b0001,
                  0, 0, 0, 1'b0, 0, 16'h0400, 6, 2);
`endif
    vecs[9]  = mk(3, 3, 64'h0000_0200_0300_0100, 64'h0000_0002_0002_0002, 4'b0000,
                  2, 3, 4, 1'b0, 1, 16'h0300, 12, 3);
    vecs[10] = mk(3, 0, 64'h0000_0300_0200_0100, 64'h0, 4'b0000,
                  5, 0, 0, 1'b0, 2, 16'h0300, 8, 3);
    vecs[11] = mk(20, 0, 64'h0, 64'h0, 4'b0000,
                  0, 0, 0, 1'b0, 15, 16'h100f, 34, 16);

    // Reset held with start high: nothing may start or strobe.
    nrst = 1'b0;
    en = 1'b1;
    start = 1'b1;
    neighborCount = 5'd3;
    hopsFromSink = 16'd3;
    load_table(vecs[0]);
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst noRoute", noRoute, 0);
    chk("rst nt_rd_en", nt_rd_en, 0);
    chk("rst nt_addr", nt_addr, 0);
    chk("rst nextHopID", nextHopID, 0);
    chk("rst nextHopQ", nextHopQ, 0);
    chk("rst nextHopIdx", nextHopIdx, 0);
    chk("rst strobes", strobes, 0);
    nrst = 1'b1;
    start = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(k, vecs[k]);

    // Reset in mid-scan aborts with no done and clears results.
    @(negedge clk);
    load_table(vecs[0]);
    neighborCount = 5'd3;
    hopsFromSink = 16'd3;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    st_r = strobes;
    chk("midrst busy", busy, 0);
    chk("midrst nt_rd_en", nt_rd_en, 0);
    chk("midrst nextHopIdx", nextHopIdx, 0);
    chk("midrst nextHopQ", nextHopQ, 0);
    chk("midrst nextHopID", nextHopID, 0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk("midrst no_done_or_busy", dn, 0);
    chk("midrst no_strobes", strobes - st_r, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
